// File: rtl/window_peak_tracker_pkg.sv
// Shared types and defaults for the windowed max/min tracker.
package window_peak_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_WINDOW = 8;
  localparam int unsigned COUNT_W    = 16;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/window_peak_tracker_if.sv
// Sample-in / result-out handshake bundle for window_peak_tracker.
interface window_peak_tracker_if #(
  parameter int unsigned WIDTH = window_peak_pkg::DEF_WIDTH
);

  logic                                sample_valid;
  logic [WIDTH-1:0]                    sample_data;
  logic                                sample_ready;
  logic                                result_valid;
  logic                                result_ready;
  logic [WIDTH-1:0]                    result_max;
  logic [WIDTH-1:0]                    result_min;
  logic                                result_all_eq;
  logic [window_peak_pkg::COUNT_W-1:0] sample_count;

  modport master (
    output sample_valid, sample_data, result_ready,
    input  sample_ready, result_valid, result_max, result_min,
           result_all_eq, sample_count
  );

  modport slave (
    input  sample_valid, sample_data, result_ready,
    output sample_ready, result_valid, result_max, result_min,
           result_all_eq, sample_count
  );

endinterface

// File: rtl/window_peak_tracker_mag_compare16.sv
// Combinational unsigned magnitude compare, width set by parameter.
module mag_compare16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  always_comb begin
    gt_o = (a_i > b_i);
    lt_o = (a_i < b_i);
    eq_o = (a_i == b_i);
  end

endmodule

// File: rtl/window_peak_tracker.sv
// Tracks running max/min over WINDOW accepted samples and presents the
// result on a held valid/ready port.
module window_peak_tracker
  import window_peak_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned WINDOW = DEF_WINDOW
) (
  input  logic                 clk,
  input  logic                 rst,
  window_peak_tracker_if.slave bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   run_max_q, run_min_q;
  logic [WIDTH-1:0]   res_max_q, res_min_q;
  logic               res_eq_q, res_valid_q;
  logic [COUNT_W-1:0] count_q;

  logic               sample_ready;
  logic               accept;
  logic               max_gt, min_lt;
  logic               max_lt_unused, max_eq_unused, min_gt_unused, min_eq_unused;
  logic [WIDTH-1:0]   upd_max, upd_min;
  logic               last_sample;

  mag_compare16 #(.WIDTH(WIDTH)) u_cmp_max (
    .a_i  (bus.sample_data),
    .b_i  (run_max_q),
    .gt_o (max_gt),
    .lt_o (max_lt_unused),
    .eq_o (max_eq_unused)
  );

  mag_compare16 #(.WIDTH(WIDTH)) u_cmp_min (
    .a_i  (bus.sample_data),
    .b_i  (run_min_q),
    .gt_o (min_gt_unused),
    .lt_o (min_lt),
    .eq_o (min_eq_unused)
  );

  always_comb begin
    sample_ready = (state_q != HOLD);
    accept       = bus.sample_valid && sample_ready;
    upd_max      = max_gt ? bus.sample_data : run_max_q;
    upd_min      = min_lt ? bus.sample_data : run_min_q;
    last_sample  = (count_q == COUNT_W'(WINDOW - 1));
    state_d      = state_q;
    case (state_q)
      FIRST:   if (accept) state_d = ACCUM;
      ACCUM:   if (accept && last_sample) state_d = HOLD;
      HOLD:    if (bus.result_ready) state_d = FIRST;
      default: state_d = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FIRST;
      run_max_q   <= '0;
      run_min_q   <= '0;
      res_max_q   <= '0;
      res_min_q   <= '0;
      res_eq_q    <= 1'b0;
      res_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FIRST: if (accept) begin
          run_max_q <= bus.sample_data;
          run_min_q <= bus.sample_data;
          count_q   <= COUNT_W'(1);
        end
        ACCUM: if (accept) begin
          run_max_q <= upd_max;
          run_min_q <= upd_min;
          count_q   <= count_q + 1'b1;
          // Result is taken from the values including this final sample.
          if (last_sample) begin
            res_max_q   <= upd_max;
            res_min_q   <= upd_min;
            res_eq_q    <= (upd_max == upd_min);
            res_valid_q <= 1'b1;
          end
        end
        HOLD: if (bus.result_ready) begin
          res_valid_q <= 1'b0;
          count_q     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.sample_ready  = sample_ready;
  assign bus.result_valid  = res_valid_q;
  assign bus.result_max    = res_max_q;
  assign bus.result_min    = res_min_q;
  assign bus.result_all_eq = res_eq_q;
  assign bus.sample_count  = count_q;

endmodule

// File: tb/tb_window_peak_tracker.sv
// Scoreboard bench: driver pushes expected window results, monitor pops on handshake.
module tb_window_peak_tracker;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned WINDOW = 8;

  typedef struct packed {
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    logic             eq;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  window_peak_tracker_if #(.WIDTH(WIDTH)) bus ();

  window_peak_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a result handshake completes at this edge.
  always @(posedge clk) begin
    if (!rst && bus.result_valid && bus.result_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got max 0x%0h, expected no result", bus.result_max);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_max", 32'(bus.result_max), 32'(e.mx));
        check("result_min", 32'(bus.result_min), 32'(e.mn));
        check("result_all_eq", 32'(bus.result_all_eq), 32'(e.eq));
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    n = 0;
    while (!bus.sample_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got sample_ready 0, expected 1 within 100 cycles");
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] mixed [8];
    mixed = '{16'h0100, 16'h0005, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0001, 16'h1234};
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.result_ready = 1'b1;

    // Reset then idle
    idle(2);
    check("rst_sample_ready", 32'(bus.sample_ready), 32'd1);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result_max", 32'(bus.result_max), 32'd0);
    check("rst_result_min", 32'(bus.result_min), 32'd0);
    check("rst_all_eq", 32'(bus.result_all_eq), 32'd0);
    check("rst_count", 32'(bus.sample_count), 32'd0);
    rst = 1'b0;
    idle(1);

    // Mixed window
    sb_q.push_back('{mx: 16'hFFFF, mn: 16'h0001, eq: 1'b0});
    for (int i = 0; i < 7; i++) send(mixed[i]);
    check("mixed_count7", 32'(bus.sample_count), 32'd7);
    check("mixed_valid_before", 32'(bus.result_valid), 32'd0);
    send(mixed[7]);
    check("mixed_valid_latency", 32'(bus.result_valid), 32'd1);
    check("mixed_hold_ready", 32'(bus.sample_ready), 32'd0);
    idle(1);
    check("mixed_valid_drop", 32'(bus.result_valid), 32'd0);
    check("mixed_ready_back", 32'(bus.sample_ready), 32'd1);
    check("mixed_count_clear", 32'(bus.sample_count), 32'd0);
    check("mixed_max_retained", 32'(bus.result_max), 32'hFFFF);

    // Equal window
    sb_q.push_back('{mx: 16'hA5A5, mn: 16'hA5A5, eq: 1'b1});
    for (int i = 0; i < 8; i++) send(16'hA5A5);
    idle(2);

    // Back-pressure
    bus.result_ready = 1'b0;
    sb_q.push_back('{mx: 16'h0080, mn: 16'h0010, eq: 1'b0});
    for (int i = 1; i <= 8; i++) send(16'(i * 16));
    bus.sample_valid = 1'b1;
    bus.sample_data  = 16'h0042;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(bus.result_valid), 32'd1);
      check("bp_ready", 32'(bus.sample_ready), 32'd0);
      check("bp_max", 32'(bus.result_max), 32'h0080);
      check("bp_min", 32'(bus.result_min), 32'h0010);
      check("bp_count", 32'(bus.sample_count), 32'd8);
      @(negedge clk);
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    check("bp_first_ready", 32'(bus.sample_ready), 32'd1);
    check("bp_first_count", 32'(bus.sample_count), 32'd0);
    sb_q.push_back('{mx: 16'h0050, mn: 16'h0042, eq: 1'b0});
    send(16'h0042);
    check("bp_held_sample_first", 32'(bus.sample_count), 32'd1);
    for (int i = 0; i < 7; i++) send(16'h0050);
    idle(2);

    // Reset mid-window
    send(16'h0010);
    send(16'h0020);
    send(16'h0030);
    check("mid_count3", 32'(bus.sample_count), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_count", 32'(bus.sample_count), 32'd0);
    sb_q.push_back('{mx: 16'h0003, mn: 16'h0003, eq: 1'b1});
    for (int i = 0; i < 8; i++) send(16'h0003);
    idle(2);

    // Gapped input
    sb_q.push_back('{mx: 16'h0007, mn: 16'h0000, eq: 1'b0});
    for (int i = 0; i < 8; i++) begin
      send(16'(i));
      if (i < 7) @(negedge clk);
    end
    check("gap_valid", 32'(bus.result_valid), 32'd1);
    idle(3);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/window_peak_tracker.md
# window_peak_tracker

- Streaming stage that accepts unsigned samples over a valid/ready handshake and tracks the running maximum and minimum across a fixed-length window.
- At the end of each window it presents the max, the min and an all-equal flag on a valid/ready result port.
- It sits directly downstream of the sample source and wraps two unsigned magnitude compares per accepted sample, one against the running max and one against the running min.

## Interface
Clock: one clock; reset is synchronous and active-high.

Parameters:
- WIDTH, 16, sample width in bits (unsigned)
- WINDOW, 8, samples per window; legal range 2..65535

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  upstream sample present
- sample_data  in  WIDTH  unsigned sample
- sample_ready  out  1  block can accept a sample this cycle
- result_valid  out  1  window result held on result_* outputs
- result_ready  in  1  downstream consumes result
- result_max  out  WIDTH  largest sample of the completed window
- result_min  out  WIDTH  smallest sample of the completed window
- result_all_eq  out  1  every sample in the window was equal (max == min)
- sample_count  out  16  samples accepted so far in the current window

## Operation
- A sample is accepted when sample_valid && sample_ready at a rising edge.
- The state machine has three states:
  - FIRST: sample_ready=1. On accept: run_max=run_min=sample_data, sample_count=1, go to ACCUM.
  - ACCUM: sample_ready=1. On accept:
    - if sample_data > run_max, run_max=sample_data
    - if sample_data < run_min, run_min=sample_data
    - an equal value leaves both registers unchanged
    - sample_count increments
    - if this was sample number WINDOW, load result_max/result_min from the updated values, set result_all_eq = (updated max == updated min), set result_valid=1, go to HOLD.
  - HOLD: sample_ready=0; result_* stable. When result_ready=1: result_valid=0, sample_count=0, go to FIRST.
- All compares are unsigned and full WIDTH; there is no saturation or wrap.
- The sample_count width is fixed at 16, which covers the maximum WINDOW.
- sample_ready is a combinational decode of state only and never depends on sample_valid.
- result_valid is not a function of result_ready, so there is no combinational path from it.
- Upstream holds sample_data stable while sample_valid=1 && sample_ready=0, per the handshake rule. Samples presented with sample_valid=0 are ignored.
- rst has priority over every other input in the same cycle.

## Timing
- Reset values:
  - state=FIRST
  - sample_ready=1, result_valid=0
  - result_max=0, result_min=0, result_all_eq=0
  - sample_count=0
  - internal run_max/run_min=0
- Throughput is one sample per cycle in FIRST and ACCUM.
- result_valid rises the cycle after the WINDOW-th sample is accepted, so latency from last accept is 1 cycle.
- HOLD lasts at least 1 cycle. If result_ready is already high on the first HOLD cycle, FIRST is entered on the next edge, and sample_ready returns to 1 on the 2nd cycle after the last accept.
- Back-pressure: while result_ready=0, HOLD persists indefinitely with all result_* unchanged.
- result_* outputs retain their last values after the handshake until the next window completes. Only result_valid drops.
- Simultaneous events:
  - sample_valid during HOLD is not accepted. It is not lost, because upstream must hold it.
  - Reset mid-window discards the partial window.
  - Reset in HOLD drops result_valid on the next edge without a handshake.
- WINDOW=2 boundary: FIRST accepts one sample, ACCUM accepts one sample, then HOLD.

## Structure
- Package window_peak_pkg holds:
  - the state enum (FIRST, ACCUM, HOLD)
  - default WIDTH and WINDOW localparams
  - COUNT_W=16
- One natural sub-module: mag_compare16, a combinational unsigned WIDTH-bit compare with outputs gt/lt/eq.
  - Instantiated twice: sample vs run_max, and sample vs run_min.
  - It is a separate module from the existing lab comparator so it can be parameterized by WIDTH.
- Remainder is a single always_ff for state, counters and registers, plus an always_comb for next-state and sample_ready.

## Test plan
- Reset then idle: assert rst 2 cycles -> sample_ready=1, result_valid=0, result_max=result_min=0, sample_count=0.
- Mixed window (WINDOW=8), samples 0x0100, 0x0005, 0xFFFF, 0x7FFF, 0x0005, 0x8000, 0x0001, 0x1234 back-to-back:
  - result_valid rises 1 cycle after the 8th accept
  - result_max=0xFFFF, result_min=0x0001, result_all_eq=0
- Equal window: eight samples of 0xA5A5 -> result_max=result_min=0xA5A5, result_all_eq=1.
- Back-pressure:
  - hold result_ready=0 for 10 cycles after result_valid -> outputs stable, sample_ready=0, presented sample 0x0042 not accepted
  - raise result_ready -> FIRST next cycle, and 0x0042 becomes the first sample of the next window
- Reset mid-window: accept 0x0010, 0x0020, 0x0030, then rst for 1 cycle, then 8 samples of 0x0003 -> result_max=result_min=0x0003, result_all_eq=1 (no carry-over of 0x0030).
- Gapped input: toggle sample_valid 1/0 every cycle with ascending 0x0000..0x0007 -> result after 8 accepts (16 cycles): result_max=0x0007, result_min=0x0000.
